// File: rtl/toff_demux.sv
// Two-stage pipelined reversible 1-to-2 demultiplexer built from per-bit Toffoli gates.
// Define TOFF_DEMUX_ANC_CHECK_EN to build the ancilla uncompute check that drives anc_err.
module toff_demux #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] d_in,
    input  logic             fault_inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             g_sel,
    output logic [WIDTH-1:0] g_d,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             anc_err
);

    logic             s1_valid_reg;
    logic             s1_sel_reg;
    logic [WIDTH-1:0] s1_d_reg;
    logic [WIDTH-1:0] s1_t0_reg;
    logic [WIDTH-1:0] s1_t1_reg;

    logic             out_valid_reg;
    logic             g_sel_reg;
    logic [WIDTH-1:0] y0_reg;
    logic [WIDTH-1:0] y1_reg;
    logic [WIDTH-1:0] g_d_reg;
    logic [CNT_W-1:0] cnt0_reg;
    logic [CNT_W-1:0] cnt1_reg;

    logic [WIDTH-1:0] t0_next;
    logic [WIDTH-1:0] t1_next;

    logic s1_adv;
    logic in_acc;
    logic out_hs;

    // Forward Toffoli layer: target 0, control sel (inverted for lane 0) and d[gi].
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toff
            assign t0_next[gi] = ~sel & d_in[gi];
            if (gi == 0) begin : g_fault
                assign t1_next[gi] = (sel & d_in[gi]) ^ fault_inj;
            end else begin : g_clean
                assign t1_next[gi] = sel & d_in[gi];
            end
        end
    endgenerate

    assign s1_adv   = s1_valid_reg & (~out_valid_reg | out_ready);
    assign in_ready = ~s1_valid_reg | s1_adv;
    assign in_acc   = in_valid & in_ready;
    assign out_hs   = out_valid_reg & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sel_reg   <= 1'b0;
            s1_d_reg     <= '0;
            s1_t0_reg    <= '0;
            s1_t1_reg    <= '0;
        end else begin
            if (in_acc) begin
                s1_valid_reg <= 1'b1;
                s1_sel_reg   <= sel;
                s1_d_reg     <= d_in;
                s1_t0_reg    <= t0_next;
                s1_t1_reg    <= t1_next;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            g_sel_reg     <= 1'b0;
            y0_reg        <= '0;
            y1_reg        <= '0;
            g_d_reg       <= '0;
        end else begin
            if (s1_adv) begin
                out_valid_reg <= 1'b1;
                g_sel_reg     <= s1_sel_reg;
                y0_reg        <= s1_t0_reg;
                y1_reg        <= s1_t1_reg;
                g_d_reg       <= s1_d_reg;
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Counters follow the outgoing word's preserved select; they wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_reg <= '0;
            cnt1_reg <= '0;
        end else if (out_hs) begin
            if (g_sel_reg) begin
                cnt1_reg <= cnt1_reg + 1'b1;
            end else begin
                cnt0_reg <= cnt0_reg + 1'b1;
            end
        end
    end

`ifdef TOFF_DEMUX_ANC_CHECK_EN
    logic             anc_err_reg;
    logic [WIDTH-1:0] anc_residue;

    // Re-applying the same Toffolis must return both targets to zero.
    assign anc_residue = (s1_t1_reg ^ ({WIDTH{s1_sel_reg}} & s1_d_reg))
                       | (s1_t0_reg ^ ({WIDTH{~s1_sel_reg}} & s1_d_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            anc_err_reg <= 1'b0;
        end else if (s1_adv && (|anc_residue)) begin
            anc_err_reg <= 1'b1;
        end
    end

    assign anc_err = anc_err_reg;
`else
    assign anc_err = 1'b0;
`endif

    assign out_valid = out_valid_reg;
    assign g_sel     = g_sel_reg;
    assign y0        = y0_reg;
    assign y1        = y1_reg;
    assign g_d       = g_d_reg;
    assign cnt0      = cnt0_reg;
    assign cnt1      = cnt1_reg;

endmodule

// File: tb/tb_toff_demux.sv
// Directed bench for toff_demux: reset, routing, backpressure, streaming wrap,
// fault injection and mid-flight reset, each step checked with immediate assertions.
module tb_toff_demux;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

`ifdef TOFF_DEMUX_ANC_CHECK_EN
    localparam logic ANC_EXP = 1'b1;
`else
    localparam logic ANC_EXP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [WIDTH-1:0] d_in;
    logic             fault_inj;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic             g_sel;
    logic [WIDTH-1:0] g_d;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             anc_err;

    int checks   = 0;
    int failures = 0;
    int acc_n    = 0;
    logic [WIDTH-1:0] rx_q [$];

    toff_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .d_in(d_in), .fault_inj(fault_inj),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .g_sel(g_sel), .g_d(g_d),
        .cnt0(cnt0), .cnt1(cnt1), .anc_err(anc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, return 1 time unit after it.
    task automatic cyc();
        bit a;
        bit o;
        #1;
        a = in_valid && in_ready;
        o = out_valid && out_ready;
        if (o) rx_q.push_back(g_d);
        @(posedge clk);
        #1;
        if (a) acc_n++;
    endtask

    initial begin
        logic [WIDTH-1:0] bp_d   [3];
        logic             bp_sel [3];
        int n;
        int stalls;
        int lane_errs;
        int order_errs;
        int ov_seen;
        logic [WIDTH-1:0] exp_d;

        bp_d[0] = 4'h1; bp_d[1] = 4'h2; bp_d[2] = 4'h3;
        bp_sel[0] = 1'b0; bp_sel[1] = 1'b1; bp_sel[2] = 1'b0;

        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; d_in = '0;
        fault_inj = 1'b0; out_ready = 1'b0;

        // Reset
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y0", 32'(y0), 32'd0);
        check("rst_y1", 32'(y1), 32'd0);
        check("rst_g_d", 32'(g_d), 32'd0);
        check("rst_g_sel", 32'(g_sel), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_anc_err", 32'(anc_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Routing, lane 0
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 1'b0; d_in = 4'hA;
        cyc();
        in_valid = 1'b0;
        check("lat_not_yet", 32'(out_valid), 32'd0);
        cyc();
        check("r0_out_valid", 32'(out_valid), 32'd1);
        check("r0_y0", 32'(y0), 32'hA);
        check("r0_y1", 32'(y1), 32'h0);
        check("r0_g_d", 32'(g_d), 32'hA);
        check("r0_g_sel", 32'(g_sel), 32'd0);
        cyc();
        check("r0_cnt0", 32'(cnt0), 32'd1);
        check("r0_drained", 32'(out_valid), 32'd0);

        // Routing, lane 1
        in_valid = 1'b1; sel = 1'b1; d_in = 4'h5;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("r1_y1", 32'(y1), 32'h5);
        check("r1_y0", 32'(y0), 32'h0);
        check("r1_g_sel", 32'(g_sel), 32'd1);
        cyc();
        check("r1_cnt1", 32'(cnt1), 32'd1);
        check("r1_cnt0", 32'(cnt0), 32'd1);

        // Backpressure: three words offered, two fit
        out_ready = 1'b0;
        acc_n = 0;
        rx_q.delete();
        in_valid = 1'b1; sel = bp_sel[0]; d_in = bp_d[0];
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (acc_n < 3) begin
                sel = bp_sel[acc_n]; d_in = bp_d[acc_n];
            end
        end
        check("bp_accepted", 32'(acc_n), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_g_d", 32'(g_d), 32'h1);
        check("bp_hold_y0", 32'(y0), 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (acc_n < 3) begin
                sel = bp_sel[acc_n]; d_in = bp_d[acc_n];
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp_rx_count", 32'(rx_q.size()), 32'd3);
        order_errs = 0;
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            if (rx_q[i] !== bp_d[i]) order_errs++;
        end
        check("bp_order_errs", 32'(order_errs), 32'd0);
        check("bp_cnt0", 32'(cnt0), 32'd3);
        check("bp_cnt1", 32'(cnt1), 32'd2);

        // Streaming 300 words on lane 1
        rst = 1'b1; cyc(); rst = 1'b0;
        acc_n = 0;
        rx_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 1'b1; d_in = '0;
        n = 0; stalls = 0; lane_errs = 0;
        while (rx_q.size() < 300 && n < 400) begin
            cyc();
            n++;
            if (acc_n >= 300) in_valid = 1'b0;
            d_in = acc_n[WIDTH-1:0];
            if (in_valid && !in_ready) stalls++;
            if (out_valid && (y0 !== '0 || y1 !== g_d)) lane_errs++;
        end
        check("st_rx_count", 32'(rx_q.size()), 32'd300);
        check("st_cycles", 32'(n), 32'd302);
        check("st_stalls", 32'(stalls), 32'd0);
        check("st_lane_errs", 32'(lane_errs), 32'd0);
        order_errs = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            exp_d = WIDTH'(i);
            if (rx_q[i] !== exp_d) order_errs++;
        end
        check("st_order_errs", 32'(order_errs), 32'd0);
        check("st_cnt1_wrap", 32'(cnt1), 32'd44);
        check("st_cnt0", 32'(cnt0), 32'd0);

        // Fault injection
        rst = 1'b1; cyc(); rst = 1'b0;
        in_valid = 1'b1; sel = 1'b0; d_in = 4'h3; fault_inj = 1'b1;
        cyc();
        in_valid = 1'b0; fault_inj = 1'b0;
        cyc();
        check("fi_out_valid", 32'(out_valid), 32'd1);
        check("fi_y1", 32'(y1), 32'h1);
        check("fi_y0", 32'(y0), 32'h3);
        check("fi_anc_err", 32'(anc_err), 32'(ANC_EXP));
        acc_n = 0;
        in_valid = 1'b1; sel = 1'b1; d_in = 4'h6;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (acc_n >= 10) in_valid = 1'b0;
        end
        check("fi_cnt0", 32'(cnt0), 32'd1);
        check("fi_cnt1", 32'(cnt1), 32'd10);
        check("fi_anc_sticky", 32'(anc_err), 32'(ANC_EXP));
        rst = 1'b1; cyc(); rst = 1'b0;
        check("fi_anc_cleared", 32'(anc_err), 32'd0);

        // Mid-flight reset
        in_valid = 1'b1; sel = 1'b0; d_in = 4'h9;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        check("mf_pre_cnt0", 32'(cnt0), 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b1; d_in = 4'h7;
        cyc();
        d_in = 4'h8;
        cyc();
        in_valid = 1'b0;
        check("mf_loaded", 32'(out_valid), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("mf_out_valid", 32'(out_valid), 32'd0);
        check("mf_cnt0", 32'(cnt0), 32'd0);
        check("mf_cnt1", 32'(cnt1), 32'd0);
        check("mf_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (out_valid) ov_seen++;
        end
        check("mf_no_stale", 32'(ov_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
